alu_pipe: RTL

- Parametrised successor of the team's single-issue ALU.
- Generalised data width; per-operation signed/unsigned mode; tag passthrough; REM operation.
- Full valid/ready backpressure on the output, with throughput of 1 op/cycle for single-cycle ops.
- Iterative multi-cycle divider for DIV/REM.
- Sits between an operand-issue stage and a result-writeback stage; a differential-test model consumes the debug outputs.

---
 rtl/alu_pipe.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: single-issue ALU with a registered, backpressured result stage.
// Single-cycle ops load the output register at the accept edge. DIV/REM run
// on an iterative restoring divider. Results leave in request order.
module alu_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 4,
    parameter int SIGNED_EN  = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic [DATA_WIDTH-1:0]         a_i,
    input  logic [DATA_WIDTH-1:0]         b_i,
    input  logic [3:0]                    op_i,
    input  logic                          signed_i,
    input  logic [TAG_WIDTH-1:0]          tag_i,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [DATA_WIDTH-1:0]         result_o,
    output logic [TAG_WIDTH-1:0]          tag_o,
    output logic                          overflow_o,
    output logic                          zero_o,
    output logic                          busy_o,
    output logic [$clog2(DATA_WIDTH):0]   debug_div_cnt_o
);

    // state  | meaning
    // IDLE   | divider free, single-cycle ops may be accepted
    // ITER   | one restoring-division step per cycle on the magnitudes
    // DONE   | sign-corrected result waiting for a free output register

    localparam int DW   = DATA_WIDTH;
    localparam int SHW  = $clog2(DATA_WIDTH);
    localparam int CNTW = SHW + 1;

    localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_MUL = 4'd2,  OP_DIV = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4,  OP_OR  = 4'd5,  OP_XOR = 4'd6,  OP_NOT = 4'd7;
    localparam logic [3:0] OP_SHL = 4'd8,  OP_SHR = 4'd9,  OP_ROL = 4'd10, OP_ROR = 4'd11;
    localparam logic [3:0] OP_MAX = 4'd12, OP_MIN = 4'd13, OP_CMP = 4'd14, OP_REM = 4'd15;

    localparam logic [DW-1:0] MIN_NEG = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} div_state_e;

    div_state_e           state_q, state_d;
    logic [CNTW-1:0]      cnt_q;
    logic [DW-1:0]        rem_q, quo_q, dvs_q;
    logic                 neg_q_q, neg_r_q, rem_op_q;
    logic [TAG_WIDTH-1:0] tag_div_q;

    logic                 valid_q, ovf_q, zero_q;
    logic [DW-1:0]        res_q;
    logic [TAG_WIDTH-1:0] tag_q;

    logic                 sgn, a_neg, b_neg, accept, div_load;
    logic                 is_divop, div_zero, div_ovf, div_start;
    logic [DW-1:0]        a_mag, b_mag;
    logic [DW:0]          sum_w, dif_w, shift_w, trial_w;
    logic [2*DW-1:0]      a_ext, b_ext, prod_w;
    logic [SHW-1:0]       amt;
    logic [CNTW-1:0]      inv_amt;
    logic signed [DW-1:0] a_s;
    logic [DW-1:0]        sra_w, div_q_fix, div_r_fix, sc_res;
    logic                 a_gt, a_lt, sc_ovf;

    // Operand conditioning shared by the single-cycle path and the divider.
    always_comb begin
        sgn       = (SIGNED_EN != 0) && signed_i;
        a_neg     = sgn && a_i[DW-1];
        b_neg     = sgn && b_i[DW-1];
        a_mag     = a_neg ? -a_i : a_i;
        b_mag     = b_neg ? -b_i : b_i;
        is_divop  = (op_i == OP_DIV) || (op_i == OP_REM);
        div_zero  = (b_i == '0);
        div_ovf   = sgn && (a_i == MIN_NEG) && (b_i == '1);
        div_start = is_divop && !div_zero && !div_ovf;
        accept    = valid_i && ready_o;
        sum_w     = {1'b0, a_i} + {1'b0, b_i};
        dif_w     = {1'b0, a_i} - {1'b0, b_i};
        a_ext     = sgn ? {{DW{a_i[DW-1]}}, a_i} : {{DW{1'b0}}, a_i};
        b_ext     = sgn ? {{DW{b_i[DW-1]}}, b_i} : {{DW{1'b0}}, b_i};
        prod_w    = a_ext * b_ext;
        amt       = b_i[SHW-1:0];
        inv_amt   = CNTW'(DW) - CNTW'(amt);
        a_s       = a_i;
        sra_w     = a_s >>> amt;
        a_gt      = sgn ? ($signed(a_i) > $signed(b_i)) : (a_i > b_i);
        a_lt      = sgn ? ($signed(a_i) < $signed(b_i)) : (a_i < b_i);
    end

    // Single-cycle result and overflow, including the DIV/REM special cases.
    always_comb begin
        sc_res = '0;
        sc_ovf = 1'b0;
        case (op_i)
            OP_ADD: begin
                sc_res = sum_w[DW-1:0];
                sc_ovf = sgn ? ((a_i[DW-1] == b_i[DW-1]) && (sum_w[DW-1] != a_i[DW-1])) : sum_w[DW];
            end
            OP_SUB: begin
                sc_res = dif_w[DW-1:0];
                sc_ovf = sgn ? ((a_i[DW-1] != b_i[DW-1]) && (dif_w[DW-1] != a_i[DW-1])) : dif_w[DW];
            end
            OP_MUL: begin
                sc_res = prod_w[DW-1:0];
                sc_ovf = sgn ? (prod_w[2*DW-1:DW] != {DW{prod_w[DW-1]}}) : (prod_w[2*DW-1:DW] != '0);
            end
            OP_DIV, OP_REM: begin
                sc_ovf = 1'b1;
                if (div_zero) sc_res = (op_i == OP_DIV) ? '1 : a_i;
                else          sc_res = (op_i == OP_DIV) ? MIN_NEG : '0;
            end
            OP_AND: sc_res = a_i & b_i;
            OP_OR:  sc_res = a_i | b_i;
            OP_XOR: sc_res = a_i ^ b_i;
            OP_NOT: sc_res = ~a_i;
            OP_SHL: sc_res = a_i << amt;
            OP_SHR: sc_res = sgn ? sra_w : (a_i >> amt);
            OP_ROL: sc_res = (a_i << amt) | (a_i >> inv_amt);
            OP_ROR: sc_res = (a_i >> amt) | (a_i << inv_amt);
            OP_MAX: sc_res = a_gt ? a_i : b_i;
            OP_MIN: sc_res = a_lt ? a_i : b_i;
            OP_CMP: sc_res = (a_i == b_i) ? '0 : (a_gt ? DW'(1) : '1);
            default: sc_res = '0;
        endcase
    end

    // Divider FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Divider FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept && div_start)           state_d = S_ITER;
            S_ITER: if (cnt_q == CNTW'(DW - 1))        state_d = S_DONE;
            S_DONE: if (!valid_q || ready_i)           state_d = S_IDLE;
            default:                                   state_d = S_IDLE;
        endcase
    end

    // Divider FSM outputs: handshake and the DONE-to-output load strobe.
    always_comb begin
        busy_o   = (state_q != S_IDLE);
        ready_o  = (state_q == S_IDLE) && (!valid_q || ready_i);
        div_load = (state_q == S_DONE) && (!valid_q || ready_i);
    end

    // Restoring division step and the final sign correction.
    always_comb begin
        shift_w   = {rem_q, quo_q[DW-1]};
        trial_w   = shift_w - {1'b0, dvs_q};
        div_q_fix = neg_q_q ? -quo_q : quo_q;
        div_r_fix = neg_r_q ? -rem_q : rem_q;
    end

    // Divider datapath: latch magnitudes at accept, then one quotient bit per cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            rem_op_q  <= 1'b0;
            tag_div_q <= '0;
        end else if (state_q == S_IDLE && accept && div_start) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= a_mag;
            dvs_q     <= b_mag;
            neg_q_q   <= a_neg ^ b_neg;
            neg_r_q   <= a_neg;
            rem_op_q  <= (op_i == OP_REM);
            tag_div_q <= tag_i;
        end else if (state_q == S_ITER) begin
            cnt_q <= cnt_q + CNTW'(1);
            rem_q <= trial_w[DW] ? shift_w[DW-1:0] : trial_w[DW-1:0];
            quo_q <= {quo_q[DW-2:0], !trial_w[DW]};
        end
    end

    // Output register: loads single-cycle results at accept, divider results from DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            res_q   <= '0;
            tag_q   <= '0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b1;
        end else if (accept && !div_start) begin
            valid_q <= 1'b1;
            res_q   <= sc_res;
            tag_q   <= tag_i;
            ovf_q   <= sc_ovf;
            zero_q  <= (sc_res == '0);
        end else if (div_load) begin
            valid_q <= 1'b1;
            res_q   <= rem_op_q ? div_r_fix : div_q_fix;
            tag_q   <= tag_div_q;
            ovf_q   <= 1'b0;
            zero_q  <= ((rem_op_q ? div_r_fix : div_q_fix) == '0);
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o         = valid_q;
    assign result_o        = res_q;
    assign tag_o           = tag_q;
    assign overflow_o      = ovf_q;
    assign zero_o          = zero_q;
    assign debug_div_cnt_o = cnt_q;

endmodule
